// File: rtl/dmem_pkg.sv
// Shared definitions for the data memory controller.
// Holds the controller state encoding, the response status codes and the
// address range check used when a request is accepted.
package dmem_pkg;

   // Controller states, in the order a request walks through them
   typedef enum logic [2:0] {
      IDLE,
      WAIT,
      ACC0,
      ACC1,
      ERR,
      RESP
   } state_e;

   // Response status codes carried on rsp_err
   localparam logic RSP_OK  = 1'b0;
   localparam logic RSP_ERR = 1'b1;

   // True when the last word touched by the request lies outside the array.
   // The sum is formed one bit wider than the address so that a double
   // access at the top of the address space cannot wrap back into range.
   function automatic logic out_of_range(input logic [31:0] addr,
                                         input logic        dbl,
                                         input logic [31:0] depth);
      logic [32:0] lastWord;
      lastWord = {1'b0, addr} + {32'd0, dbl};
      return (lastWord >= {1'b0, depth});
   endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port synchronous word RAM.
// Ports:
//   clk_i    clock
//   we_i     write enable, writes wdata_i to addr_i on the rising edge
//   addr_i   word address
//   wdata_i  write data
//   rdata_o  registered read data of the word addressed on the previous edge
// The contents are not reset.
module dmem_array #(
   parameter int DATA_W = 16,
   parameter int DEPTH  = 2048,
   parameter int AW     = $clog2(DEPTH)
) (
   input  logic              clk_i,
   input  logic              we_i,
   input  logic [AW-1:0]     addr_i,
   input  logic [DATA_W-1:0] wdata_i,
   output logic [DATA_W-1:0] rdata_o
);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [DATA_W-1:0] rdata_q;

   // Storage array plus output register; a read happens every cycle so the
   // controller only has to steer the address one cycle ahead of use
   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem[addr_i] <= wdata_i;
      end
      rdata_q <= mem[addr_i];
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/data_memory_ctrl.sv
// Data memory controller for the MEM stage.
// Word RAM behind a valid/ready request and a one-cycle response pulse, with
// optional wait states, two-word accesses and out-of-range error reporting.
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   req_valid/req_ready    request handshake, accepted when both high
//   req_write, req_double  write/read select, two-word access select
//   req_addr, req_wdata    word address, write data (high word first)
//   rsp_valid              one-cycle response pulse
//   rsp_rdata, rsp_err     read data and error flag, held between responses
module data_memory_ctrl
   import dmem_pkg::*;
#(
   parameter int DATA_W   = 16,
   parameter int ADDR_W   = 16,
   parameter int DEPTH    = 2048,
   parameter int WAIT_CYC = 0
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic                req_write,
   input  logic                req_double,
   input  logic [ADDR_W-1:0]   req_addr,
   input  logic [2*DATA_W-1:0] req_wdata,
   output logic                rsp_valid,
   output logic [2*DATA_W-1:0] rsp_rdata,
   output logic                rsp_err
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [3:0] WAIT_LAST = (WAIT_CYC > 0) ? 4'(WAIT_CYC - 1) : 4'd0;

   state_e              state_q, state_d;
   logic [3:0]          cnt_q, cnt_d;
   logic [AW-1:0]       addr_q, addr_d;
   logic                write_q, write_d;
   logic                double_q, double_d;
   logic [2*DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0]   word0_q, word0_d;
   logic [2*DATA_W-1:0] rdata_q, rdata_d;
   logic                err_q, err_d;

   logic                ramWe;
   logic [AW-1:0]       ramAddr;
   logic [DATA_W-1:0]   ramWdata;
   logic [DATA_W-1:0]   ramRdata;
   logic [AW-1:0]       addrNext;

   // Only in-range addresses are ever latched, so the second word of a
   // double access cannot wrap inside the index width
   assign addrNext = addr_q + 1'b1;

   dmem_array #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .AW     (AW)
   ) u_array (
      .clk_i   (clk),
      .we_i    (ramWe),
      .addr_i  (ramAddr),
      .wdata_i (ramWdata),
      .rdata_o (ramRdata)
   );

   // Next-state and RAM steering. The RAM output is registered, so the address
   // presented in a state is the word needed in the following state: in IDLE
   // the incoming address primes the first word for a zero-wait ACC0, and in
   // ACC0 of a double read addr+1 is fetched for ACC1.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      addr_d   = addr_q;
      write_d  = write_q;
      double_d = double_q;
      wdata_d  = wdata_q;
      word0_d  = word0_q;
      rdata_d  = rdata_q;
      err_d    = err_q;
      ramWe    = 1'b0;
      ramAddr  = addr_q;
      ramWdata = wdata_q[DATA_W-1:0];
      case (state_q)
         IDLE: begin
            ramAddr = req_addr[AW-1:0];
            if (req_valid) begin
               addr_d   = req_addr[AW-1:0];
               write_d  = req_write;
               double_d = req_double;
               wdata_d  = req_wdata;
               cnt_d    = 4'd0;
               if (out_of_range(32'(req_addr), req_double, 32'(DEPTH))) begin
                  state_d = ERR;
               end else if (WAIT_CYC > 0) begin
                  state_d = WAIT;
               end else begin
                  state_d = ACC0;
               end
            end
         end
         WAIT: begin
            if (cnt_q == WAIT_LAST) begin
               state_d = ACC0;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         ACC0: begin
            ramWe = write_q;
            if (double_q) begin
               ramWdata = wdata_q[2*DATA_W-1:DATA_W];
               if (!write_q) begin
                  ramAddr = addrNext;
               end
               word0_d = ramRdata;
               state_d = ACC1;
            end else begin
               rdata_d = write_q ? '0 : {{DATA_W{1'b0}}, ramRdata};
               err_d   = RSP_OK;
               state_d = RESP;
            end
         end
         ACC1: begin
            ramWe   = write_q;
            ramAddr = addrNext;
            rdata_d = write_q ? '0 : {word0_q, ramRdata};
            err_d   = RSP_OK;
            state_d = RESP;
         end
         ERR: begin
            rdata_d = '0;
            err_d   = RSP_ERR;
            state_d = RESP;
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and request/response registers; reset drops any request in flight
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         cnt_q    <= 4'd0;
         addr_q   <= '0;
         write_q  <= 1'b0;
         double_q <= 1'b0;
         wdata_q  <= '0;
         word0_q  <= '0;
         rdata_q  <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         addr_q   <= addr_d;
         write_q  <= write_d;
         double_q <= double_d;
         wdata_q  <= wdata_d;
         word0_q  <= word0_d;
         rdata_q  <= rdata_d;
         err_q    <= err_d;
      end
   end

   assign req_ready = (state_q == IDLE);
   assign rsp_valid = (state_q == RESP);
   assign rsp_rdata = rdata_q;
   assign rsp_err   = err_q;

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Self-checking bench for data_memory_ctrl.
// Two instances share the request inputs: u0 without wait states and u1 with
// three. A select flag picks whose outputs the transaction task follows.
module tb_data_memory_ctrl;

   localparam int DEPTH = 2048;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        reqValid, reqWrite, reqDouble;
   logic [15:0] reqAddr;
   logic [31:0] reqWdata;
   logic        rdy0, rsp0, err0;
   logic [31:0] rdata0;
   logic        rdy1, rsp1, err1;
   logic [31:0] rdata1;

   logic        sel;
   logic        selReady, selRsp, selErr;
   logic [31:0] selRdata;

   int          total = 0;
   int          bad = 0;
   int          cycle = 0;

   logic [15:0] model [DEPTH];

   typedef struct {
      string       name;
      logic        wr;
      logic        dbl;
      logic [15:0] addr;
      logic [31:0] wdata;
      logic [31:0] expRdata;
      logic        expErr;
      int          expLat;
   } vec_t;

   vec_t vecs[$];

   always #5 clk = ~clk;

   always @(posedge clk) cycle <= cycle + 1;

   data_memory_ctrl #(.DATA_W(16), .ADDR_W(16), .DEPTH(DEPTH), .WAIT_CYC(0)) u0 (
      .clk(clk), .rst_n(rst_n), .req_valid(reqValid), .req_ready(rdy0),
      .req_write(reqWrite), .req_double(reqDouble), .req_addr(reqAddr),
      .req_wdata(reqWdata), .rsp_valid(rsp0), .rsp_rdata(rdata0), .rsp_err(err0)
   );

   data_memory_ctrl #(.DATA_W(16), .ADDR_W(16), .DEPTH(DEPTH), .WAIT_CYC(3)) u1 (
      .clk(clk), .rst_n(rst_n), .req_valid(reqValid), .req_ready(rdy1),
      .req_write(reqWrite), .req_double(reqDouble), .req_addr(reqAddr),
      .req_wdata(reqWdata), .rsp_valid(rsp1), .rsp_rdata(rdata1), .rsp_err(err1)
   );

   assign selReady = sel ? rdy1   : rdy0;
   assign selRsp   = sel ? rsp1   : rsp0;
   assign selErr   = sel ? err1   : err0;
   assign selRdata = sel ? rdata1 : rdata0;

   // One comparison: counts it and reports a failure line on mismatch
   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Reference behaviour of a write: high word first for a double access
   task automatic modelWrite(input logic dbl, input logic [15:0] a, input logic [31:0] wd);
      if (dbl) begin
         model[a]         = wd[31:16];
         model[16'(a + 1)] = wd[15:0];
      end else begin
         model[a] = wd[15:0];
      end
   endtask

   // Full transaction on the selected instance. Returns response data, error,
   // latency in cycles from the accept cycle, accept cycle, and the number of
   // busy cycles in which req_ready was seen high. With scramble set the
   // request fields are randomised while the controller is busy.
   task automatic applyStimulus(input logic w, input logic d, input logic [15:0] a,
                                input logic [31:0] wd, input logic scramble,
                                output logic [31:0] rd, output logic er,
                                output int lat, output int acc, output int busyReady);
      int  guard;
      logic got;
      rd = '0; er = 1'b0; lat = -1; busyReady = 0; got = 1'b0;
      @(negedge clk);
      reqValid = 1'b1; reqWrite = w; reqDouble = d; reqAddr = a; reqWdata = wd;
      guard = 0;
      while (!selReady && guard < 40) begin
         @(negedge clk);
         guard++;
      end
      acc = cycle;
      if (!selReady) begin
         total++; bad++;
         $display("[TB] FAIL accept_timeout actual=busy required=ready");
         reqValid = 1'b0;
         return;
      end
      guard = 0;
      do begin
         @(negedge clk);
         guard++;
         if (selRsp) begin
            got = 1'b1;
            rd  = selRdata;
            er  = selErr;
            lat = cycle - acc;
            reqValid = 1'b0;
         end else begin
            if (selReady) busyReady++;
            if (scramble) begin
               reqValid  = 1'($urandom);
               reqWrite  = 1'($urandom);
               reqDouble = 1'($urandom);
               reqAddr   = 16'($urandom);
               reqWdata  = $urandom;
            end else begin
               reqValid = 1'b0;
            end
         end
      end while (!got && guard < 40);
      if (!got) begin
         total++; bad++;
         reqValid = 1'b0;
         $display("[TB] FAIL response_timeout actual=none required=rsp_valid");
      end
   endtask

   task automatic addVec(input string n, input logic w, input logic d, input logic [15:0] a,
                         input logic [31:0] wd, input logic [31:0] er, input logic ee, input int l);
      vec_t v;
      v.name = n; v.wr = w; v.dbl = d; v.addr = a; v.wdata = wd;
      v.expRdata = er; v.expErr = ee; v.expLat = l;
      vecs.push_back(v);
   endtask

   initial begin
      logic [31:0] rd, expRd;
      logic        er, expErr, w, d;
      logic [15:0] a;
      logic [31:0] wd;
      int          lat, acc, accPrev, busy, c0, r1c, r2c, readyHigh, sawRsp, last;
      logic [31:0] d1, d2;
      logic        readyAt6;

      sel = 1'b0;
      rst_n = 1'b0;
      reqValid = 1'b0; reqWrite = 1'b0; reqDouble = 1'b0; reqAddr = '0; reqWdata = '0;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset_ready", 32'(rdy0), 32'd1);
      checkOutput("reset_rsp_valid", 32'(rsp0), 32'd0);
      checkOutput("reset_rdata", rdata0, 32'd0);
      checkOutput("reset_err", 32'(err0), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Directed table: name, write, double, addr, wdata, rdata, err, latency
      addVec("wr_0010",     1, 0, 16'h0010, 32'h0000_1234, 32'h0,         0, 2);
      addVec("rd_0010",     0, 0, 16'h0010, 32'h0,         32'h0000_1234, 0, 2);
      addVec("dwr_0100",    1, 1, 16'h0100, 32'hAAAA_5555, 32'h0,         0, 3);
      addVec("rd_0100",     0, 0, 16'h0100, 32'h0,         32'h0000_AAAA, 0, 2);
      addVec("rd_0101",     0, 0, 16'h0101, 32'h0,         32'h0000_5555, 0, 2);
      addVec("drd_0100",    0, 1, 16'h0100, 32'h0,         32'hAAAA_5555, 0, 3);
      addVec("wr_07ff",     1, 0, 16'h07FF, 32'h0000_C0DE, 32'h0,         0, 2);
      addVec("rd_0800_err", 0, 0, 16'h0800, 32'h0,         32'h0,         1, 2);
      addVec("drd_07ff_err",0, 1, 16'h07FF, 32'h0,         32'h0,         1, 2);
      addVec("dwr_07ff_err",1, 1, 16'h07FF, 32'h1234_5678, 32'h0,         1, 2);
      addVec("wr_0800_err", 1, 0, 16'h0800, 32'h0000_DEAD, 32'h0,         1, 2);
      addVec("drd_ffff_err",0, 1, 16'hFFFF, 32'h0,         32'h0,         1, 2);
      addVec("rd_07ff",     0, 0, 16'h07FF, 32'h0,         32'h0000_C0DE, 0, 2);
      addVec("dwr_07fe",    1, 1, 16'h07FE, 32'h9999_AAAA, 32'h0,         0, 3);
      addVec("drd_07fe",    0, 1, 16'h07FE, 32'h0,         32'h9999_AAAA, 0, 3);
      addVec("wr_0020",     1, 0, 16'h0020, 32'h0000_BEEF, 32'h0,         0, 2);
      addVec("rd_0020",     0, 0, 16'h0020, 32'h0,         32'h0000_BEEF, 0, 2);

      accPrev = 0;
      foreach (vecs[i]) begin
         applyStimulus(vecs[i].wr, vecs[i].dbl, vecs[i].addr, vecs[i].wdata, 1'b1,
                       rd, er, lat, acc, busy);
         checkOutput({vecs[i].name, "_rdata"}, rd, vecs[i].expRdata);
         checkOutput({vecs[i].name, "_err"}, 32'(er), 32'(vecs[i].expErr));
         checkOutput({vecs[i].name, "_lat"}, 32'(lat), 32'(vecs[i].expLat));
         checkOutput({vecs[i].name, "_busy_ready"}, 32'(busy), 32'd0);
         if (vecs[i].wr && !vecs[i].expErr) modelWrite(vecs[i].dbl, vecs[i].addr, vecs[i].wdata);
         if (vecs[i].name == "rd_0020") checkOutput("b2b_accept_gap", 32'(acc - accPrev), 32'd3);
         accPrev = acc;
      end

      // Fill a scratch region so random reads always hit known words
      for (int i = 0; i < 64; i++) begin
         wd = {16'h0, 16'($urandom)};
         a  = 16'(16'h0300 + i);
         applyStimulus(1'b1, 1'b0, a, wd, 1'b1, rd, er, lat, acc, busy);
         modelWrite(1'b0, a, wd);
         checkOutput("fill_err", 32'(er), 32'd0);
      end

      // Random mix against the model
      for (int n = 0; n < 80; n++) begin
         w  = 1'($urandom);
         d  = 1'($urandom);
         wd = $urandom;
         if ($urandom_range(0, 3) == 0) begin
            a = ($urandom_range(0, 1) == 1) ? 16'h07FF : 16'($urandom_range(16'h0800, 16'hFFFF));
         end else begin
            a = 16'(16'h0300 + $urandom_range(0, 62));
         end
         last   = int'(a) + int'(d);
         expErr = (last >= DEPTH);
         expRd  = '0;
         if (!expErr) begin
            if (w) modelWrite(d, a, wd);
            else expRd = d ? {model[a], model[16'(a + 1)]} : {16'h0, model[a]};
         end
         applyStimulus(w, d, a, wd, 1'b1, rd, er, lat, acc, busy);
         checkOutput("rand_rdata", rd, expRd);
         checkOutput("rand_err", 32'(er), 32'(expErr));
         checkOutput("rand_lat", 32'(lat), expErr ? 32'd2 : 32'(2 + int'(d)));
      end

      // Reset during ACC1 of a double write
      applyStimulus(1'b1, 1'b0, 16'h0200, 32'h0000_0BAD, 1'b0, rd, er, lat, acc, busy);
      applyStimulus(1'b1, 1'b0, 16'h0201, 32'h0000_7777, 1'b0, rd, er, lat, acc, busy);
      applyStimulus(1'b0, 1'b0, 16'h0201, 32'h0, 1'b0, rd, er, lat, acc, busy);
      checkOutput("pre_reset_rdata", rd, 32'h0000_7777);
      @(negedge clk);
      reqValid = 1'b1; reqWrite = 1'b1; reqDouble = 1'b1;
      reqAddr = 16'h0200; reqWdata = 32'h1111_2222;
      checkOutput("abort_ready", 32'(rdy0), 32'd1);
      @(posedge clk);
      #1 reqValid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      checkOutput("abort_rsp_valid", 32'(rsp0), 32'd0);
      checkOutput("abort_ready_now", 32'(rdy0), 32'd1);
      checkOutput("abort_rdata", rdata0, 32'd0);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      sawRsp = 0;
      repeat (4) begin
         @(negedge clk);
         if (rsp0) sawRsp++;
      end
      checkOutput("abort_no_rsp", 32'(sawRsp), 32'd0);
      applyStimulus(1'b0, 1'b0, 16'h0200, 32'h0, 1'b0, rd, er, lat, acc, busy);
      checkOutput("abort_rd_0200", rd, 32'h0000_1111);
      applyStimulus(1'b0, 1'b0, 16'h0201, 32'h0, 1'b0, rd, er, lat, acc, busy);
      checkOutput("abort_rd_0201", rd, 32'h0000_7777);

      // Wait-state instance
      sel = 1'b1;
      applyStimulus(1'b1, 1'b0, 16'h0040, 32'h0000_5A5A, 1'b0, rd, er, lat, acc, busy);
      checkOutput("wait_wr_lat", 32'(lat), 32'd5);
      @(negedge clk);
      reqValid = 1'b1; reqWrite = 1'b0; reqDouble = 1'b0; reqAddr = 16'h0040; reqWdata = '0;
      checkOutput("wait_idle_ready", 32'(rdy1), 32'd1);
      c0 = cycle; r1c = -1; r2c = -1; readyHigh = 0; readyAt6 = 1'b0; d1 = '0; d2 = '0;
      for (int k = 1; k <= 11; k++) begin
         @(negedge clk);
         if (k <= 5 && rdy1) readyHigh++;
         if (k == 6) readyAt6 = rdy1;
         if (rsp1) begin
            if (r1c < 0) begin r1c = cycle - c0; d1 = rdata1; end
            else begin r2c = cycle - c0; d2 = rdata1; end
         end
      end
      reqValid = 1'b0;
      checkOutput("wait_rsp1_cycle", 32'(r1c), 32'd5);
      checkOutput("wait_rsp2_cycle", 32'(r2c), 32'd11);
      checkOutput("wait_rsp1_rdata", d1, 32'h0000_5A5A);
      checkOutput("wait_rsp2_rdata", d2, 32'h0000_5A5A);
      checkOutput("wait_busy_ready", 32'(readyHigh), 32'd0);
      checkOutput("wait_ready_again", 32'(readyAt6), 32'd1);

      repeat (3) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
